// File: rtl/vote_session_ctrl_if.sv
// Voting-session bus: control/voter inputs and round status/result outputs.
// The master drives a round; the slave is the session controller.
interface vote_session_ctrl_if #(
    parameter int N_VOTERS = 8,
    parameter int WIN_W    = 16
);
    localparam int CW = $clog2(N_VOTERS + 1);

    logic                start;
    logic                abort;
    logic [WIN_W-1:0]    window_len;
    logic [N_VOTERS-1:0] votes;
    logic                busy;
    logic                ballot_open;
    logic                done;
    logic                pass;
    logic [CW-1:0]       tally;
    logic [N_VOTERS-1:0] voted;

    modport master (
        output start, abort, window_len, votes,
        input  busy, ballot_open, done, pass, tally, voted
    );

    modport slave (
        input  start, abort, window_len, votes,
        output busy, ballot_open, done, pass, tally, voted
    );
endinterface

// File: rtl/vote_session_ctrl.sv
// One timed voting round: synchronize voters, latch first votes during the
// ballot window, tally serially one voter per cycle, compare against quorum.
module vote_session_ctrl #(
    parameter int N_VOTERS = 8,
    parameter int WIN_W    = 16,
    parameter int QUORUM   = 5
) (
    input  logic               clk,
    input  logic               rst,
    vote_session_ctrl_if.slave bus
);
    localparam int CW = $clog2(N_VOTERS + 1);
    localparam int IW = (N_VOTERS > 1) ? $clog2(N_VOTERS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_TALLY, S_RESULT} state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [N_VOTERS-1:0] r_sync1;
    logic [N_VOTERS-1:0] r_sync2;
    logic [N_VOTERS-1:0] r_voted;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [WIN_W-1:0]    w_win_load;
    logic [IW-1:0]       r_idx;
    logic [CW-1:0]       r_tally;
    logic [CW-1:0]       w_tally_nx;
    logic                r_pass;
    logic                w_accept;
    logic                w_last_open;
    logic                w_last_tally;

    assign w_accept     = bus.start && !bus.abort;
    assign w_win_load   = (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
    assign w_last_open  = (r_win_cnt == WIN_W'(1));
    assign w_last_tally = (r_idx == IW'(N_VOTERS - 1));
    assign w_tally_nx   = r_tally + CW'(r_voted[r_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.votes;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nx = S_OPEN;
            S_OPEN:   if (bus.abort) w_state_nx = S_IDLE;
                      else if (w_last_open) w_state_nx = S_TALLY;
            S_TALLY:  if (bus.abort) w_state_nx = S_IDLE;
                      else if (w_last_tally) w_state_nx = S_RESULT;
            S_RESULT: w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // Pass is resolved on the last tally edge so it is valid alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_voted   <= '0;
            r_win_cnt <= '0;
            r_idx     <= '0;
            r_tally   <= '0;
            r_pass    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_win_cnt <= w_win_load;
                        r_voted   <= '0;
                        r_tally   <= '0;
                        r_pass    <= 1'b0;
                        r_idx     <= '0;
                    end
                end
                S_OPEN: begin
                    if (bus.abort) begin
                        r_voted <= '0;
                        r_tally <= '0;
                        r_pass  <= 1'b0;
                    end else begin
                        r_voted   <= r_voted | r_sync2;
                        r_win_cnt <= r_win_cnt - WIN_W'(1);
                        if (w_last_open) begin
                            r_idx   <= '0;
                            r_tally <= '0;
                        end
                    end
                end
                S_TALLY: begin
                    if (bus.abort) begin
                        r_voted <= '0;
                        r_tally <= '0;
                        r_pass  <= 1'b0;
                        r_idx   <= '0;
                    end else begin
                        r_tally <= w_tally_nx;
                        if (w_last_tally) begin
                            r_idx  <= '0;
                            r_pass <= (w_tally_nx >= CW'(QUORUM));
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy        = (r_state != S_IDLE);
        bus.ballot_open = (r_state == S_OPEN);
        bus.done        = (r_state == S_RESULT);
        bus.pass        = r_pass;
        bus.tally       = r_tally;
        bus.voted       = r_voted;
    end
endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl: table of complete rounds plus
// hand-written abort, ignored-start, idle start+abort and async-reset sequences.
module tb_vote_session_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    vote_session_ctrl_if #(.N_VOTERS(8), .WIN_W(16)) vif ();

    vote_session_ctrl #(.N_VOTERS(8), .WIN_W(16), .QUORUM(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    always @(negedge clk) if (vif.done) done_cnt++;

    typedef struct {
        logic [15:0] wl;
        logic [7:0]  base;
        int          pc;     // cycle after t0 at which pmask is pulsed (0 = none)
        logic [7:0]  pmask;
        int          lat;
        int          tally;
        int          pass;
        logic [7:0]  voted;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic run_round(input vec_t v, input string tag);
        int n;
        int nopen;
        bit got;
        vif.votes = v.base;
        repeat (3) @(negedge clk);
        vif.window_len = v.wl;
        vif.start = 1'b1;
        @(negedge clk);
        vif.start = 1'b0;
        n = 1; nopen = 0; got = 0;
        while (n <= 200) begin
            if (vif.ballot_open) nopen++;
            if (v.pc != 0 && n == v.pc) vif.votes = v.base | v.pmask;
            else vif.votes = v.base;
            if (vif.done) begin got = 1; break; end
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, got ? n : -1, v.lat);
        chk({tag, " open_cycles"}, nopen, (v.wl == 0) ? 1 : int'(v.wl));
        chk({tag, " tally"}, vif.tally, v.tally);
        chk({tag, " pass"}, vif.pass, v.pass);
        chk({tag, " voted"}, vif.voted, v.voted);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, {vif.done, vif.busy}, 0);
        chk({tag, " tally_held"}, vif.tally, v.tally);
    endtask

    initial begin
        int n;
        int d0;
        vif.start = 0; vif.abort = 0; vif.window_len = '0; vif.votes = '0;

        vecs[0] = '{16'd3, 8'h17, 0, 8'h00, 12, 4, 0, 8'h17};
        vecs[1] = '{16'd6, 8'h0F, 1, 8'hF0, 15, 8, 1, 8'hFF};
        vecs[2] = '{16'd2, 8'h0F, 3, 8'hF0, 11, 4, 0, 8'h0F};
        vecs[3] = '{16'd0, 8'hFF, 0, 8'h00, 10, 8, 1, 8'hFF};
        vecs[4] = '{16'd5, 8'h1F, 0, 8'h00, 14, 5, 1, 8'h1F};
        vecs[5] = '{16'd1, 8'h00, 0, 8'h00, 10, 0, 0, 8'h00};
        vecs[6] = '{16'd4, 8'h80, 0, 8'h00, 13, 1, 0, 8'h80};

        repeat (2) @(negedge clk);
        chk("reset outputs", {vif.busy, vif.ballot_open, vif.done, vif.pass}, 0);
        chk("reset tally_voted", {vif.tally, vif.voted}, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_round(vecs[i], $sformatf("vec%0d", i));

        // Abort on the 4th TALLY cycle.
        vif.votes = 8'hFF;
        repeat (3) @(negedge clk);
        vif.window_len = 16'd2; vif.start = 1'b1;
        @(negedge clk);
        vif.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort pre tally", vif.tally, 3);
        chk("abort pre state", {vif.busy, vif.ballot_open}, 2'b10);
        d0 = done_cnt;
        vif.abort = 1'b1;
        @(negedge clk);
        vif.abort = 1'b0;
        chk("abort busy", vif.busy, 0);
        chk("abort cleared", {vif.tally, vif.voted, vif.pass}, 0);
        repeat (15) @(negedge clk);
        chk("abort no done", done_cnt - d0, 0);
        run_round(vecs[0], "after_abort");

        // Start during OPEN and during RESULT is ignored; IDLE start after RESULT accepted.
        d0 = done_cnt;
        vif.votes = 8'h03;
        repeat (3) @(negedge clk);
        vif.window_len = 16'd4; vif.start = 1'b1;
        @(negedge clk);
        vif.start = 1'b0;
        n = 1;
        while (n <= 200 && !vif.done) begin
            vif.start = (n == 2);
            @(negedge clk);
            n++;
        end
        chk("ign_start latency", n, 13);
        chk("ign_start tally", vif.tally, 2);
        vif.start = 1'b1;
        @(negedge clk);
        chk("start in RESULT ignored", vif.busy, 0);
        @(negedge clk);
        vif.start = 1'b0;
        chk("start after RESULT accepted", {vif.busy, vif.ballot_open}, 2'b11);
        n = 0;
        while (n < 200 && !vif.done) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("one done per start", done_cnt - d0, 2);

        // start+abort together in IDLE: stays IDLE, results held.
        vif.start = 1'b1; vif.abort = 1'b1;
        @(negedge clk);
        vif.start = 1'b0; vif.abort = 1'b0;
        chk("idle start+abort busy", vif.busy, 0);
        chk("idle start+abort held", {vif.tally, vif.voted}, {4'd2, 8'h03});
        @(negedge clk);
        chk("idle start+abort still idle", vif.busy, 0);

        // Asynchronous reset in the middle of OPEN.
        vif.votes = 8'hFF;
        repeat (3) @(negedge clk);
        vif.window_len = 16'd10; vif.start = 1'b1;
        @(negedge clk);
        vif.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst pre voted", {vif.ballot_open, vif.voted}, {1'b1, 8'hFF});
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("rst async outputs", {vif.busy, vif.ballot_open, vif.done, vif.pass}, 0);
        chk("rst async tally_voted", {vif.tally, vif.voted}, 0);
        chk("rst sync flops", {dut.r_sync1, dut.r_sync2}, 0);
        @(negedge clk);
        chk("rst held sync flops", {dut.r_sync1, dut.r_sync2}, 0);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("rst no done", done_cnt - d0, 0);
        chk("rst idle", vif.busy, 0);
        run_round(vecs[4], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
